// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered MIPS-style execute unit with valid/ready handshakes on both
// sides. Single-cycle ops (add/sub/logic/shift/compare) produce a result
// one cycle after acceptance. With ALU_MULDIV_EN defined, MULT/MULTU/DIV/DIVU
// run an iterative shift-add / restoring-divide engine for WIDTH cycles and
// return a HI/LO pair. Without the macro those opcodes behave as undefined.
//
// Configuration macro: ALU_MULDIV_EN (multiply/divide datapath and BUSY state)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     operation request from issue
//   in_ready     unit idle and able to accept an operation
//   op           4-bit operation code
//   a, b         WIDTH-bit two's complement operands
//   shamt        shift amount applied to a
//   out_valid    result available
//   out_ready    writeback takes the result
//   result       main result (LO / quotient)
//   result_hi    HI / remainder, 0 for non-muldiv ops
//   overflow     signed overflow
//   zero         a == b at acceptance
//   div_by_zero  divide with b == 0
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               overflow,
    output logic               zero,
    output logic               div_by_zero
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_SGT = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_NOR = 4'd9;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t r_state;
    state_t w_nextState;

    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_resHi;
    logic             w_ovf;
    logic             w_zero;
    logic             w_dbz;
    logic             w_startMd;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_resultHi;
    logic             r_overflow;
    logic             r_zero;
    logic             r_dbz;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    // Single-cycle result computed straight from the live operands; it is
    // only captured on the accept edge. Ops that need the iterative engine
    // raise w_startMd instead of producing a value here.
    always_comb begin
        w_res     = '0;
        w_resHi   = '0;
        w_ovf     = 1'b0;
        w_zero    = (a == b);
        w_dbz     = 1'b0;
        w_startMd = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_SLL: w_res = a << shamt;
            OP_SRL: w_res = a >> shamt;
            OP_SRA: w_res = $signed(a) >>> shamt;
            OP_SGT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: w_res = ~(a | b);
`ifdef ALU_MULDIV_EN
            OP_MULT, OP_MULTU: w_startMd = 1'b1;
            OP_DIV, OP_DIVU: begin
                // Divide by zero short-circuits the engine entirely.
                if (b == '0) begin
                    w_dbz   = 1'b1;
                    w_res   = '1;
                    w_resHi = a;
                end else begin
                    w_startMd = 1'b1;
                end
            end
`endif
            default: w_zero = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic [SHAMT_W-1:0] r_count;
    logic               r_isDiv;
    logic               r_negLo;
    logic               r_negHi;
    logic               r_pendOvf;
    logic               r_pendZero;

    logic               w_signedOp;
    logic               w_isDivOp;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH:0]     w_divTrial;
    logic               w_divFits;
    logic [WIDTH-1:0]   w_stepHi;
    logic [WIDTH-1:0]   w_stepLo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodNeg;
    logic [WIDTH-1:0]   w_finHi;
    logic [WIDTH-1:0]   w_finLo;
    logic               w_lastStep;

    assign w_signedOp = (op == OP_MULT) || (op == OP_DIV);
    assign w_isDivOp  = (op == OP_DIV) || (op == OP_DIVU);
    assign w_magA     = (w_signedOp && a[WIDTH-1]) ? -a : a;
    assign w_magB     = (w_signedOp && b[WIDTH-1]) ? -b : b;

    // Multiply: {r_hi, r_lo} is the product register with the multiplier
    // shifting out of r_lo; the carry of the add lands in the top bit.
    assign w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);

    // Divide: r_hi is the partial remainder, dividend bits shift out of the
    // top of r_lo while quotient bits shift in at the bottom.
    assign w_divShift = {r_hi, r_lo[WIDTH-1]};
    assign w_divTrial = w_divShift - {1'b0, r_mcand};
    assign w_divFits  = ~w_divTrial[WIDTH];

    assign w_lastStep = (r_state == S_BUSY) && (r_count == SHAMT_W'(WIDTH - 1));

    // One engine step; the step output also feeds the final sign fix so the
    // result is ready on the same edge as the last iteration.
    always_comb begin
        if (r_isDiv) begin
            w_stepHi = w_divFits ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];
            w_stepLo = {r_lo[WIDTH-2:0], w_divFits};
        end else begin
            w_stepHi = w_mulSum[WIDTH:1];
            w_stepLo = {w_mulSum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign w_prod    = {w_stepHi, w_stepLo};
    assign w_prodNeg = -w_prod;

    // Signed ops ran on magnitudes; restore signs here. The product is
    // negated as one double-width value, while quotient and remainder are
    // fixed independently (remainder follows the dividend).
    always_comb begin
        if (r_isDiv) begin
            w_finLo = r_negLo ? -w_stepLo : w_stepLo;
            w_finHi = r_negHi ? -w_stepHi : w_stepHi;
        end else if (r_negLo) begin
            w_finLo = w_prodNeg[WIDTH-1:0];
            w_finHi = w_prodNeg[2*WIDTH-1:WIDTH];
        end else begin
            w_finLo = w_prod[WIDTH-1:0];
            w_finHi = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    // Engine registers: loaded with magnitudes and sign bookkeeping on the
    // accept edge, then stepped once per BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_mcand    <= '0;
            r_count    <= '0;
            r_isDiv    <= 1'b0;
            r_negLo    <= 1'b0;
            r_negHi    <= 1'b0;
            r_pendOvf  <= 1'b0;
            r_pendZero <= 1'b0;
        end else if (w_accept && w_startMd) begin
            r_hi       <= '0;
            r_lo       <= w_magA;
            r_mcand    <= w_magB;
            r_count    <= '0;
            r_isDiv    <= w_isDivOp;
            r_negLo    <= w_signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_negHi    <= w_signedOp && (w_isDivOp ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
            r_pendOvf  <= (op == OP_DIV) && (a == MOST_NEG) && (b == '1);
            r_pendZero <= w_zero;
        end else if (r_state == S_BUSY) begin
            r_hi    <= w_stepHi;
            r_lo    <= w_stepLo;
            r_count <= r_count + SHAMT_W'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: single-cycle ops jump straight to DONE, muldiv ops
    // spend WIDTH cycles in BUSY, and DONE waits for the consumer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef ALU_MULDIV_EN
                    w_nextState = w_startMd ? S_BUSY : S_DONE;
`else
                    w_nextState = S_DONE;
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                if (w_lastStep) begin
                    w_nextState = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Output registers only change on an accept or on engine completion,
    // neither of which can happen in DONE, so the result holds under
    // backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result   <= '0;
            r_resultHi <= '0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_dbz      <= 1'b0;
        end else if (w_accept && !w_startMd) begin
            r_result   <= w_res;
            r_resultHi <= w_resHi;
            r_overflow <= w_ovf;
            r_zero     <= w_zero;
            r_dbz      <= w_dbz;
        end
`ifdef ALU_MULDIV_EN
        else if (w_lastStep) begin
            r_result   <= w_finLo;
            r_resultHi <= w_finHi;
            r_overflow <= r_pendOvf;
            r_zero     <= r_pendZero;
            r_dbz      <= 1'b0;
        end
`endif
    end

    assign result      = r_result;
    assign result_hi   = r_resultHi;
    assign overflow    = r_overflow;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;

endmodule
